// File: rtl/phase_timer.sv
// Four-phase main/side-road junction timer advanced by an external tick strobe.
// Owns the phase sequence, supports early side-green termination, hold and force-to-main.
module phase_timer #(
  parameter int CW       = 6,
  parameter int T_MG     = 60,
  parameter int T_MY     = 4,
  parameter int T_CG     = 20,
  parameter int T_CG_MIN = 5,
  parameter int T_CY     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          c_sensor,
  input  logic          hold,
  input  logic          force_main,
  output logic [1:0]    phase,
  output logic [CW-1:0] count,
  output logic          carry_flag,
  output logic [2:0]    main_lamp,
  output logic [2:0]    side_lamp
);

  // state | meaning
  // MGCR  | main green, side red
  // MYCR  | main yellow, side red
  // MRCG  | main red, side green
  // MRCY  | main red, side yellow
  typedef enum logic [1:0] {
    MGCR = 2'd0,
    MYCR = 2'd1,
    MRCG = 2'd2,
    MRCY = 2'd3
  } phase_t;

  localparam logic [CW-1:0] L_MG  = CW'(T_MG);
  localparam logic [CW-1:0] L_MY  = CW'(T_MY);
  localparam logic [CW-1:0] L_CG  = CW'(T_CG);
  localparam logic [CW-1:0] L_CY  = CW'(T_CY);
  localparam logic [CW-1:0] L_ONE = CW'(1);
  // Side green may end early once count has fallen to this value (T_CG_MIN ticks spent).
  localparam logic [CW-1:0] L_EARLY = CW'(T_CG - T_CG_MIN + 1);

  phase_t        state, state_nx;
  logic [CW-1:0] count_nx;
  logic          carry_nx;
  logic          sync_a, sync_b;
  logic          adv;

  assign adv   = tick & ~hold;
  assign phase = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= c_sensor;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MGCR;
      count      <= L_MG;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      carry_flag <= carry_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    carry_nx = 1'b0;
    if (adv) begin
      case (state)
        MGCR: begin
          if (force_main) begin
            count_nx = L_MG;
          end else if (count != L_ONE) begin
            count_nx = count - L_ONE;
          end else if (sync_b) begin
            state_nx = MYCR;
            count_nx = L_MY;
            carry_nx = 1'b1;
          end else begin
            count_nx = L_MG;
            carry_nx = 1'b1;
          end
        end
        MYCR: begin
          // force_main deliberately does not shorten yellow
          if (count != L_ONE) begin
            count_nx = count - L_ONE;
          end else begin
            state_nx = MRCG;
            count_nx = L_CG;
            carry_nx = 1'b1;
          end
        end
        MRCG: begin
          if (force_main || (!sync_b && count <= L_EARLY) || count == L_ONE) begin
            state_nx = MRCY;
            count_nx = L_CY;
            carry_nx = 1'b1;
          end else begin
            count_nx = count - L_ONE;
          end
        end
        MRCY: begin
          if (count != L_ONE) begin
            count_nx = count - L_ONE;
          end else begin
            state_nx = MGCR;
            count_nx = L_MG;
            carry_nx = 1'b1;
          end
        end
        default: begin
          state_nx = MGCR;
          count_nx = L_MG;
        end
      endcase
    end
  end

  always_comb begin
    main_lamp = 3'b100;
    side_lamp = 3'b100;
    case (state)
      MGCR: begin main_lamp = 3'b001; side_lamp = 3'b100; end
      MYCR: begin main_lamp = 3'b010; side_lamp = 3'b100; end
      MRCG: begin main_lamp = 3'b100; side_lamp = 3'b001; end
      MRCY: begin main_lamp = 3'b100; side_lamp = 3'b010; end
      default: begin main_lamp = 3'b100; side_lamp = 3'b100; end
    endcase
  end

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: default and wide configurations share stimulus;
// an elapsed-ticks reference model predicts outputs, a monitor compares them.
module tb_phase_timer;

  localparam int CW0 = 6, MG0 = 60, MY0 = 4, CG0 = 20, CGM0 = 5, CY0 = 4;
  localparam int CW1 = 8, MG1 = 200, MY1 = 4, CG1 = 90, CGM1 = 10, CY1 = 4;

  logic clk = 1'b0;
  logic rst, tick, c_sensor, hold, force_main;

  logic [1:0]     ph0, ph1;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;
  logic           car0, car1;
  logic [2:0]     ml0, sl0, ml1, sl1;

  phase_timer #(.CW(CW0), .T_MG(MG0), .T_MY(MY0), .T_CG(CG0), .T_CG_MIN(CGM0), .T_CY(CY0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .c_sensor(c_sensor), .hold(hold), .force_main(force_main),
    .phase(ph0), .count(cnt0), .carry_flag(car0), .main_lamp(ml0), .side_lamp(sl0));

  phase_timer #(.CW(CW1), .T_MG(MG1), .T_MY(MY1), .T_CG(CG1), .T_CG_MIN(CGM1), .T_CY(CY1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .c_sensor(c_sensor), .hold(hold), .force_main(force_main),
    .phase(ph1), .count(cnt1), .carry_flag(car1), .main_lamp(ml1), .side_lamp(sl1));

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int cnt;
    int car;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  // reference state: phase and ticks already spent in it; count is derived
  int dur[2][4] = '{'{MG0, MY0, CG0, CY0}, '{MG1, MY1, CG1, CY1}};
  int cgmin[2]  = '{CGM0, CGM1};
  int mph[2], mel[2], mcar[2], h1[2], h2[2];

  function automatic bit legal(int cw, int a, int b, int c, int cm, int e);
    int mx;
    mx = (1 << cw) - 1;
    return a >= 1 && a <= mx && b >= 1 && b <= mx && c >= 1 && c <= mx &&
           e >= 1 && e <= mx && cm >= 1 && cm <= c;
  endfunction

  initial begin
    if (!legal(CW0, MG0, MY0, CG0, CGM0, CY0) || !legal(CW1, MG1, MY1, CG1, CGM1, CY1)) begin
      $display("FAIL param_legality got illegal timing parameters, required legal set");
      $fatal(1, "illegal parameters");
    end
  end

  function automatic void enter(int d, int p);
    mcar[d] = 1;
    mph[d]  = p;
    mel[d]  = 0;
  endfunction

  function automatic void model_step(int d);
    int s;
    s     = h2[d];
    h2[d] = h1[d];
    h1[d] = int'(c_sensor);
    mcar[d] = 0;
    if (!rst) begin
      mph[d] = 0; mel[d] = 0; h1[d] = 0; h2[d] = 0;
      return;
    end
    if (!tick || hold) return;
    case (mph[d])
      0: begin
        if (force_main) mel[d] = 0;
        else if (mel[d] < dur[d][0] - 1) mel[d]++;
        else enter(d, (s != 0) ? 1 : 0);
      end
      2: begin
        if (force_main || (s == 0 && mel[d] + 1 >= cgmin[d]) || mel[d] == dur[d][2] - 1)
          enter(d, 3);
        else mel[d]++;
      end
      default: begin
        if (mel[d] < dur[d][mph[d]] - 1) mel[d]++;
        else enter(d, (mph[d] == 1) ? 2 : 0);
      end
    endcase
  endfunction

  function automatic logic [5:0] lamps(int p);
    case (p)
      0: return {3'b001, 3'b100};
      1: return {3'b010, 3'b100};
      2: return {3'b100, 3'b001};
      default: return {3'b100, 3'b010};
    endcase
  endfunction

  task automatic compare(int d, exp_t e, int aph, int acnt, int acar, logic [5:0] al);
    logic [5:0] el;
    checks++;
    if (aph != e.ph || acnt != e.cnt || acar != e.car) begin
      errors++;
      $display("FAIL dut%0d_state t=%0t got ph=%0d cnt=%0d carry=%0d required ph=%0d cnt=%0d carry=%0d",
               d, $time, aph, acnt, acar, e.ph, e.cnt, e.car);
    end
    el = lamps(e.ph);
    checks++;
    if (al != el) begin
      errors++;
      $display("FAIL dut%0d_lamps t=%0t got %b required %b", d, $time, al, el);
    end
  endtask

  // monitor: DUT presents a fresh output every clock; pop and compare shortly after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, int'(ph0), int'(cnt0), int'(car0), {ml0, sl0});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, int'(ph1), int'(cnt1), int'(car1), {ml1, sl1});
      end
    end
  end

  task automatic cyc(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        model_step(d);
        e.ph  = mph[d];
        e.cnt = dur[d][mph[d]] - mel[d];
        e.car = mcar[d];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      #3;
    end
  endtask

  task automatic wait_for(string name, int p, int el, int bound);
    int n;
    n = 0;
    while (!(mph[0] == p && mel[0] == el) && n < bound) begin
      cyc(1);
      n++;
    end
    if (!(mph[0] == p && mel[0] == el)) begin
      checks++;
      errors++;
      $display("FAIL wait_%s got ph=%0d el=%0d required ph=%0d el=%0d within %0d clks",
               name, mph[0], mel[0], p, el, bound);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; c_sensor = 1'b0; hold = 1'b0; force_main = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mph[d] = 0; mel[d] = 0; mcar[d] = 0; h1[d] = 0; h2[d] = 0;
    end
    #2;
    cyc(3);
    rst = 1'b1;
    cyc(1);

    // no side demand: main green reloads every T_MG ticks
    tick = 1'b1;
    cyc(130);

    // steady demand, then early side-green termination after sensor drops
    c_sensor = 1'b1;
    wait_for("mrcg_el2", 2, 2, 200);
    c_sensor = 1'b0;
    wait_for("mrcy_early", 3, 0, 30);
    c_sensor = 1'b1;
    wait_for("mrcg_el10", 2, 10, 200);
    c_sensor = 1'b0;
    wait_for("mrcy_early2", 3, 0, 30);
    c_sensor = 1'b1;

    // hold freezes yellow, hold dominates force_main
    wait_for("mycr_el1", 1, 1, 200);
    hold = 1'b1;
    cyc(7);
    hold = 1'b0;
    cyc(1);
    hold = 1'b1; force_main = 1'b1;
    cyc(5);
    hold = 1'b0; force_main = 1'b0;

    // force in side green at count 15, force pinned in main green, force in yellow
    wait_for("mrcg_el5", 2, 5, 200);
    force_main = 1'b1;
    cyc(1);
    force_main = 1'b0;
    wait_for("mgcr_after_force", 0, 0, 30);
    force_main = 1'b1;
    cyc(80);
    force_main = 1'b0;
    wait_for("mycr_el0", 1, 0, 200);
    force_main = 1'b1;
    for (int n = 0; n < 10 && mph[0] == 1; n++) cyc(1);
    force_main = 1'b0;

    // asynchronous reset at MRCY count 2
    wait_for("mrcy_cnt2", 3, CY0 - 2, 200);
    rst = 1'b0;
    #1;
    checks++;
    if (ph0 != 2'd0 || int'(cnt0) != MG0 || car0 != 1'b0) begin
      errors++;
      $display("FAIL async_reset got ph=%0d cnt=%0d carry=%0d required ph=0 cnt=%0d carry=0",
               ph0, cnt0, car0, MG0);
    end
    cyc(2);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick       = ($urandom % 4) != 0;
      hold       = ($urandom % 8) == 0;
      force_main = ($urandom % 16) == 0;
      if (($urandom % 10) == 0) c_sensor = ~c_sensor;
      cyc(1);
    end

    // full cycle of both configurations with steady demand
    tick = 1'b0; hold = 1'b0; force_main = 1'b0; c_sensor = 1'b1;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    tick = 1'b1;
    cyc(320);

    tick = 1'b0;
    cyc(2);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
